// File: rtl/ntt_butterfly_pipe_if.sv
// Handshake and data bundle for the pipelined NTT butterfly.
// The slave modport is the butterfly's view; the master modport is the engine or bench view.
interface ntt_butterfly_pipe_if #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_w;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [TAG_W-1:0] out_tag;
   logic             out_mode;
   logic             busy;
   logic             range_err;

   modport slave (
      input  in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
      output in_ready, out_valid, out_a, out_b, out_tag, out_mode, busy, range_err
   );

   modport master (
      output in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_tag, out_mode, busy, range_err
   );
endinterface

// File: rtl/ntt_butterfly_pipe.sv
// Four-stage CT/GS modular butterfly with a global stall: S1 pre add/sub, S2 multiply,
// S3 Barrett reduction, S4 post add/sub and output register.
module ntt_butterfly_pipe #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned Q     = 3329,
   parameter int unsigned TAG_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ntt_butterfly_pipe_if.slave  bus
);
   localparam int unsigned PW = 2 * WIDTH + 1;

   localparam logic [WIDTH-1:0] QN  = WIDTH'(Q);
   localparam logic [PW-1:0]    QP  = PW'(Q);
   localparam logic [PW-1:0]    QP2 = PW'(2 * Q);
   // Barrett constant floor(2^(2*WIDTH) / Q); leaves the remainder in [0, 3Q).
   localparam logic [PW-1:0]    MU  = {1'b1, {(PW - 1){1'b0}}} / QP;

   function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, QN}) s = s - {1'b0, QN};
      return WIDTH'(s);
   endfunction

   function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH:0] d;
      d = {1'b0, x} - {1'b0, y};
      if (x < y) d = d + {1'b0, QN};
      return WIDTH'(d);
   endfunction

   logic                 en;

   logic                 s1_valid_q, s1_mode_q;
   logic [TAG_W-1:0]     s1_tag_q;
   logic [WIDTH-1:0]     s1_a_q, s1_m_q, s1_w_q;
   logic [WIDTH-1:0]     s1_a_d, s1_m_d;

   logic                 s2_valid_q, s2_mode_q;
   logic [TAG_W-1:0]     s2_tag_q;
   logic [WIDTH-1:0]     s2_a_q;
   logic [2*WIDTH-1:0]   s2_prod_q;

   logic                 s3_valid_q, s3_mode_q;
   logic [TAG_W-1:0]     s3_tag_q;
   logic [WIDTH-1:0]     s3_a_q, s3_t_q;
   logic [WIDTH-1:0]     s3_t_d;

   logic                 s4_valid_q, s4_mode_q;
   logic [TAG_W-1:0]     s4_tag_q;
   logic [WIDTH-1:0]     s4_a_q, s4_b_q;
   logic [WIDTH-1:0]     s4_a_d, s4_b_d;

   logic                 range_err_q;
   logic                 range_hit;

   logic [PW-1:0]        red_p, red_q, red_r;
   logic [2*PW-1:0]      red_pm;

   // A single enable for every stage: bubbles are kept, nothing moves while the output stalls.
   assign en = !s4_valid_q || bus.out_ready;

   always_comb begin
      s1_a_d    = bus.in_a;
      s1_m_d    = bus.in_b;
      if (bus.in_mode) begin
         s1_a_d = add_mod(bus.in_a, bus.in_b);
         s1_m_d = sub_mod(bus.in_a, bus.in_b);
      end
      range_hit = (bus.in_a >= QN) || (bus.in_b >= QN) || (bus.in_w >= QN);
   end

   always_comb begin
      red_p  = PW'(s2_prod_q);
      red_pm = (2 * PW)'(red_p) * (2 * PW)'(MU);
      red_q  = PW'(red_pm >> (2 * WIDTH));
      red_r  = red_p - red_q * QP;
      if (red_r >= QP2) begin
         red_r = red_r - QP2;
      end else if (red_r >= QP) begin
         red_r = red_r - QP;
      end
      s3_t_d = WIDTH'(red_r);
   end

   always_comb begin
      s4_a_d = s3_a_q;
      s4_b_d = s3_t_q;
      if (!s3_mode_q) begin
         s4_a_d = add_mod(s3_a_q, s3_t_q);
         s4_b_d = sub_mod(s3_a_q, s3_t_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_tag_q   <= '0;
         s1_a_q     <= '0;
         s1_m_q     <= '0;
         s1_w_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_mode_q  <= 1'b0;
         s2_tag_q   <= '0;
         s2_a_q     <= '0;
         s2_prod_q  <= '0;
         s3_valid_q <= 1'b0;
         s3_mode_q  <= 1'b0;
         s3_tag_q   <= '0;
         s3_a_q     <= '0;
         s3_t_q     <= '0;
         s4_valid_q <= 1'b0;
         s4_mode_q  <= 1'b0;
         s4_tag_q   <= '0;
         s4_a_q     <= '0;
         s4_b_q     <= '0;
      end else if (en) begin
         s1_valid_q <= bus.in_valid;
         s1_mode_q  <= bus.in_mode;
         s1_tag_q   <= bus.in_tag;
         s1_a_q     <= s1_a_d;
         s1_m_q     <= s1_m_d;
         s1_w_q     <= bus.in_w;
         s2_valid_q <= s1_valid_q;
         s2_mode_q  <= s1_mode_q;
         s2_tag_q   <= s1_tag_q;
         s2_a_q     <= s1_a_q;
         s2_prod_q  <= (2 * WIDTH)'(s1_m_q) * (2 * WIDTH)'(s1_w_q);
         s3_valid_q <= s2_valid_q;
         s3_mode_q  <= s2_mode_q;
         s3_tag_q   <= s2_tag_q;
         s3_a_q     <= s2_a_q;
         s3_t_q     <= s3_t_d;
         s4_valid_q <= s3_valid_q;
         s4_mode_q  <= s3_mode_q;
         s4_tag_q   <= s3_tag_q;
         s4_a_q     <= s4_a_d;
         s4_b_q     <= s4_b_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_err_q <= 1'b0;
      end else if (en && bus.in_valid && range_hit) begin
         range_err_q <= 1'b1;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = s4_valid_q;
   assign bus.out_a     = s4_a_q;
   assign bus.out_b     = s4_b_q;
   assign bus.out_tag   = s4_tag_q;
   assign bus.out_mode  = s4_mode_q;
   assign bus.busy      = s1_valid_q || s2_valid_q || s3_valid_q || s4_valid_q;
   assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Directed bench for ntt_butterfly_pipe: basic CT/GS vectors, wrap boundaries, random
// streaming under backpressure, sticky range error and asynchronous reset mid-flight.
module tb_ntt_butterfly_pipe;
   localparam int W  = 12;
   localparam int TW = 8;
   localparam int Q  = 3329;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ntt_butterfly_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   ntt_butterfly_pipe #(.WIDTH(W), .Q(Q), .TAG_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [32:0] oq[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [32:0] obs();
      return {bus.out_a, bus.out_b, bus.out_tag, bus.out_mode};
   endfunction

   // Reference results {out_a, out_b} straight from the modular definitions.
   function automatic logic [23:0] model(input logic m, input int a, input int b, input int w);
      int t, oa, ob;
      if (!m) begin
         t  = (b * w) % Q;
         oa = (a + t) % Q;
         ob = (a + Q - t) % Q;
      end else begin
         oa = (a + b) % Q;
         ob = (((a + Q - b) % Q) * w) % Q;
      end
      return {12'(oa), 12'(ob)};
   endfunction

   task automatic drive(input logic v, input logic m, input logic [11:0] a,
                        input logic [11:0] b, input logic [11:0] w, input logic [7:0] t);
      bus.in_valid = v;
      bus.in_mode  = m;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_w     = w;
      bus.in_tag   = t;
   endtask

   task automatic collect(input int ncyc);
      oq.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         if (bus.out_valid) oq.push_back(obs());
         step();
      end
   endtask

   // One transaction on an idle pipe: absent after 3 edges, present after the 4th.
   task automatic single(input string name, input logic m, input logic [11:0] a,
                         input logic [11:0] b, input logic [11:0] w, input logic [7:0] t,
                         input logic [11:0] ea, input logic [11:0] eb);
      bus.out_ready = 1'b1;
      drive(1'b1, m, a, b, w, t);
      step();
      drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
      step();
      step();
      check({name, "_early"}, 64'(bus.out_valid), 64'd0);
      step();
      check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, "_data"}, 64'(obs()), 64'({ea, eb, t, m}));
      step();
   endtask

   logic [11:0] va[64], vb[64], vw[64];
   logic [7:0]  vt[64];
   logic        vm[64];
   logic [32:0] expq[64];

   initial begin
      int          sent, recv;
      logic        stalled, acc, con;
      logic [32:0] held;

      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_range_err", 64'(bus.range_err), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_data", 64'(obs()), 64'd0);
      step();
      #3 rst_n = 1'b1;
      step();

      single("ct_basic", 1'b0, 12'd1, 12'd1, 12'd17, 8'h5A, 12'd18, 12'd3313);
      single("gs_basic", 1'b1, 12'd5, 12'd3, 12'd17, 8'h11, 12'd8, 12'd34);
      single("gs_neg", 1'b1, 12'd3, 12'd5, 12'd1, 8'h12, 12'd8, 12'd3327);
      single("ct_wrap", 1'b0, 12'd3328, 12'd3328, 12'd3328, 8'h13, 12'd0, 12'd3327);
      single("ct_zero", 1'b0, 12'd0, 12'd0, 12'd0, 8'h14, 12'd0, 12'd0);
      check("range_clean", 64'(bus.range_err), 64'd0);

      for (int i = 0; i < 64; i++) begin
         vm[i] = 1'($urandom_range(0, 1));
         va[i] = 12'($urandom_range(0, Q - 1));
         vb[i] = 12'($urandom_range(0, Q - 1));
         vw[i] = 12'($urandom_range(0, Q - 1));
         vt[i] = 8'(i * 3 + 1);
         expq[i] = {model(vm[i], int'(va[i]), int'(vb[i]), int'(vw[i])), vt[i], vm[i]};
      end
      sent = 0;
      recv = 0;
      stalled = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 2000 && recv < 64; cyc++) begin
         if (stalled) check("stall_hold", 64'(obs()), 64'(held));
         if (sent < 64) drive(1'b1, vm[sent], va[sent], vb[sent], vw[sent], vt[sent]);
         else drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
         bus.out_ready = 1'($urandom_range(0, 1));
         #1;
         check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
         acc = bus.in_valid && bus.in_ready;
         con = bus.out_valid && bus.out_ready;
         if (con) begin
            check("stream_out", 64'(obs()), 64'(expq[recv]));
            recv++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held = obs();
         if (acc) sent++;
         step();
      end
      check("stream_sent", 64'(sent), 64'd64);
      check("stream_recv", 64'(recv), 64'd64);
      drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
      collect(8);
      check("stream_no_dup", 64'(oq.size()), 64'd0);
      check("stream_idle", 64'(bus.busy), 64'd0);

      bus.out_ready = 1'b1;
      drive(1'b1, 1'b0, 12'd3329, 12'd0, 12'd0, 8'hA5);
      step();
      check("range_set", 64'(bus.range_err), 64'd1);
      drive(1'b1, 1'b0, 12'd1, 12'd1, 12'd17, 8'h3C);
      step();
      drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
      collect(8);
      check("range_count", 64'(oq.size()), 64'd2);
      if (oq.size() == 2) begin
         check("range_bad_tag", 64'(oq[0][8:1]), 64'hA5);
         check("range_next", 64'(oq[1]), 64'({12'd18, 12'd3313, 8'h3C, 1'b0}));
      end
      check("range_sticky", 64'(bus.range_err), 64'd1);

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 12'(i + 1), 12'd1, 12'd1, 8'(i + 1));
         step();
      end
      drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
      check("pre_rst_busy", 64'(bus.busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_busy", 64'(bus.busy), 64'd0);
      check("mid_rst_range_err", 64'(bus.range_err), 64'd0);
      check("mid_rst_out_data", 64'(obs()), 64'd0);
      step();
      #2 rst_n = 1'b1;
      step();
      drive(1'b1, 1'b0, 12'd2, 12'd3, 12'd4, 8'h77);
      step();
      drive(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 8'd0);
      collect(8);
      check("post_rst_count", 64'(oq.size()), 64'd1);
      if (oq.size() == 1) check("post_rst_data", 64'(oq[0]), 64'({12'd14, 12'd3319, 8'h77, 1'b0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
